// File: rtl/ef_pwm_dec32.sv
// PWM decoder: measures period and high time in prescaled ticks, with a stuck-level timeout.
// Define EF_PWM_DEC32_GLITCH_FILTER_EN to add a 3-sample stability filter on the input level.
module ef_pwm_dec32 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pwm_in,
  input  logic [3:0]  clk_src,
  input  logic        inv,
  input  logic [31:0] timeout,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        to_flag,
  output logic        level
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_presc;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [31:0]            r_cnt;
  logic [31:0]            r_hi_cap;
  logic [31:0]            r_period;
  logic [31:0]            r_high_time;
  logic                   r_load;
  logic                   r_valid;
  logic                   r_to;

  logic       w_tick;
  logic [8:0] w_tick_bit;
  logic [8:0] w_tick_mask;
  logic       w_pol;
  logic       w_lvl;
  logic       w_rise;
  logic       w_fall;
  logic       w_edge;
  logic       w_run;
  logic       w_to_hit;
  logic       w_to_fire;
  logic       w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_presc <= '0;
    else if (en) r_presc <= r_presc + 8'd1;
    else         r_presc <= '0;
  end

  // Bit k of the prescaler has just risen when its low k+1 bits read 1 followed by zeros.
  always_comb begin
    w_tick_bit  = 9'd1 << clk_src[2:0];
    w_tick_mask = (w_tick_bit << 1) - 9'd1;
    w_tick      = 1'b0;
    if (clk_src == 4'd8)
      w_tick = 1'b1;
    else if (!clk_src[3])
      w_tick = (({1'b0, r_presc} & w_tick_mask) == w_tick_bit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
  end

  assign w_pol = r_sync[SYNC_STAGES-1] ^ inv;

`ifdef EF_PWM_DEC32_GLITCH_FILTER_EN
  logic [1:0] r_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_filt <= '0;
    else     r_filt <= {r_filt[0], w_pol};
  end

  // The registered level doubles as the filter's hold value.
  assign w_lvl = ((w_pol == r_filt[0]) && (w_pol == r_filt[1])) ? w_pol : r_level;
`else
  assign w_lvl = w_pol;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level <= 1'b0;
    else     r_level <= w_lvl;
  end

  assign w_rise   = w_lvl & ~r_level;
  assign w_fall   = ~w_lvl & r_level;
  assign w_edge   = w_rise | w_fall;
  assign w_run    = en && ((r_state == HIGH) || (r_state == LOW));
  assign w_to_hit = (timeout != 32'd0) && (r_cnt == timeout) && !w_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_to_fire    = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_state_next = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_state_next = HIGH;
        HIGH: begin
          if (w_fall) begin
            w_state_next = LOW;
          end else if (w_to_hit) begin
            w_state_next = WAIT_RISE;
            w_to_fire    = 1'b1;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_next = HIGH;
            w_load       = 1'b1;
          end else if (w_to_hit) begin
            w_state_next = WAIT_RISE;
            w_to_fire    = 1'b1;
          end
        end
        default:   w_state_next = IDLE;
      endcase
    end
  end

  // A rise restarts the count with this cycle's tick, so N ticks between rises read back as N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_to_fire)
      r_cnt <= '0;
    else if (w_rise)
      r_cnt <= {31'd0, w_tick};
    else if (w_run && w_tick && !(&r_cnt))
      r_cnt <= r_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_cap    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
    end else begin
      if (w_run && (r_state == HIGH) && w_fall)
        r_hi_cap <= r_cnt;
      if (w_load) begin
        r_period    <= r_cnt;
        r_high_time <= r_hi_cap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load  <= 1'b0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_load  <= w_load;
      r_valid <= r_load & en;
      r_to    <= w_to_fire;
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid & en;
  assign to_flag   = r_to & en;
  assign level     = r_level;

endmodule

// File: tb/tb_ef_pwm_dec32.sv
// Self-checking bench for ef_pwm_dec32: table vectors, randomized PWM runs and corner sequences.
`timescale 1ns/1ps
module tb_ef_pwm_dec32;

  localparam int SYNC = 2;
`ifdef EF_PWM_DEC32_GLITCH_FILTER_EN
  localparam int FILT = 2;
`else
  localparam int FILT = 0;
`endif
  // Active pwm edge to valid: synchronizer, edge cycle, load, valid register (+ filter delay).
  localparam int LAT = SYNC + 2 + FILT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm_in;
  logic [3:0]  clk_src;
  logic        inv;
  logic [31:0] timeout;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        to_flag;
  logic        level;

  ef_pwm_dec32 #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .clk_src   (clk_src),
    .inv       (inv),
    .timeout   (timeout),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .to_flag   (to_flag),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          v_cyc[$];
  logic [31:0] v_per[$];
  logic [31:0] v_hi[$];
  int          tf_cyc[$];
  int          act_cyc[$];

  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_per.push_back(period);
      v_hi.push_back(high_time);
    end
    if (to_flag) tf_cyc.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    v_cyc.delete();
    v_per.delete();
    v_hi.delete();
    tf_cyc.delete();
    act_cyc.delete();
  endtask

  // Configuration is applied under reset with en low so a polarity flip settles before enabling.
  task automatic start_run(input logic [3:0] src, input logic iv, input logic [31:0] to);
    en     = 1'b0;
    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    clk_src = src;
    inv     = iv;
    timeout = to;
    rst     = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    clear_q();
  endtask

  task automatic drive(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      if (!inv) act_cyc.push_back(cyc);
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      if (inv) act_cyc.push_back(cyc);
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic check_run(input string tag, input int exp_cnt,
                           input logic [31:0] exp_per, input logic [31:0] exp_hi);
    check({tag, "_valid_count"}, v_cyc.size(), exp_cnt);
    for (int k = 0; k < v_cyc.size() && k + 1 < act_cyc.size(); k++) begin
      check({tag, "_period"}, v_per[k], exp_per);
      check({tag, "_high_time"}, v_hi[k], exp_hi);
      check({tag, "_latency"}, v_cyc[k] - act_cyc[k + 1], LAT);
    end
    check({tag, "_no_timeout"}, tf_cyc.size(), 0);
  endtask

  typedef struct {
    logic [3:0]  src;
    logic        iv;
    int          p;
    int          h;
    int          n;
    int          exp_cnt;
    logic [31:0] exp_per;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t tbl[6];

  int          k_sel;
  int          div;
  int          m;
  int          hm;
  int          nper;
  logic [3:0]  src_r;
  logic        iv_r;
  int          t_rise;

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    pwm_in  = 1'b0;
    clk_src = 4'd8;
    inv     = 1'b0;
    timeout = 32'd0;

    // Expected values are durations in clk divided by the tick spacing.
    tbl[0] = '{4'd8, 1'b0, 100, 30,  3, 2, 32'd100, 32'd30};
    tbl[1] = '{4'd1, 1'b0, 400, 100, 2, 1, 32'd100, 32'd25};
    tbl[2] = '{4'd8, 1'b1, 100, 30,  3, 2, 32'd100, 32'd70};
    tbl[3] = '{4'd0, 1'b0, 64,  20,  3, 2, 32'd32,  32'd10};
    tbl[4] = '{4'd12, 1'b0, 50, 20,  3, 2, 32'd0,   32'd0};
    tbl[5] = '{4'd7, 1'b0, 512, 256, 2, 1, 32'd2,   32'd1};

    @(negedge clk);
    check("reset_period", period, 32'd0);
    check("reset_high_time", high_time, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_to_flag", {31'd0, to_flag}, 32'd0);
    check("reset_level", {31'd0, level}, 32'd0);

    for (int t = 0; t < 6; t++) begin
      start_run(tbl[t].src, tbl[t].iv, 32'd0);
      drive(tbl[t].p, tbl[t].h, tbl[t].n);
      repeat (20) @(negedge clk);
      check_run("vec", tbl[t].exp_cnt, tbl[t].exp_per, tbl[t].exp_hi);
      $display("vec %0d src=%0d inv=%0d P=%0d H=%0d valids=%0d period=%0d high=%0d",
               t, tbl[t].src, tbl[t].iv, tbl[t].p, tbl[t].h, v_cyc.size(), period, high_time);
    end

    for (int r = 0; r < 16; r++) begin
      k_sel = $urandom_range(0, 4);
      if (k_sel == 4) begin
        src_r = 4'd8;
        div   = 1;
      end else begin
        src_r = k_sel[3:0];
        div   = 2 << k_sel;
      end
      iv_r = 1'($urandom_range(0, 1));
      m    = $urandom_range(6, 20);
      hm   = $urandom_range(3, m - 3);
      nper = $urandom_range(2, 3);
      start_run(src_r, iv_r, 32'd0);
      drive(m * div, hm * div, nper);
      repeat (20) @(negedge clk);
      check_run("rand", nper - 1, m, iv_r ? (m - hm) : hm);
      $display("rand %0d src=%0d inv=%0d P=%0d H=%0d valids=%0d period=%0d high=%0d",
               r, src_r, iv_r, m * div, hm * div, v_cyc.size(), period, high_time);
    end

    // Stuck-high input trips the timeout, then the decoder re-arms from WAIT_RISE.
    start_run(4'd8, 1'b0, 32'd50);
    drive(40, 12, 2);
    pwm_in = 1'b1;
    t_rise = cyc;
    repeat (SYNC + FILT + 50 + 30) @(negedge clk);
    check("to_count", tf_cyc.size(), 1);
    if (tf_cyc.size() > 0) check("to_latency", tf_cyc[0] - t_rise, SYNC + 1 + FILT + 50);
    check("to_valids", v_cyc.size(), 2);
    check("to_period_hold", period, 32'd40);
    check("to_high_hold", high_time, 32'd12);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    drive(40, 12, 2);
    // Short settle: the trailing low phase would otherwise reach the timeout again.
    repeat (5) @(negedge clk);
    check("rearm_valids", v_cyc.size(), 3);
    if (v_cyc.size() == 3) begin
      check("rearm_period", v_per[2], 32'd40);
      check("rearm_high", v_hi[2], 32'd12);
    end
    check("rearm_to_count", tf_cyc.size(), 1);
    $display("timeout seq to_flags=%0d valids=%0d period=%0d high=%0d",
             tf_cyc.size(), v_cyc.size(), period, high_time);

    // Reset in the middle of a high phase.
    start_run(4'd8, 1'b0, 32'd0);
    drive(100, 30, 2);
    check("pre_rst_period", period, 32'd100);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_period", period, 32'd0);
    check("rst_high_time", high_time, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_to_flag", {31'd0, to_flag}, 32'd0);
    check("rst_level", {31'd0, level}, 32'd0);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    clear_q();
    repeat (6) @(negedge clk);
    drive(100, 30, 3);
    repeat (20) @(negedge clk);
    check_run("post_rst", 2, 32'd100, 32'd30);
    $display("reset seq valids=%0d period=%0d high=%0d", v_cyc.size(), period, high_time);

    // Two-clock glitch inside every low phase.
    start_run(4'd8, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      pwm_in = 1'b1;
      act_cyc.push_back(cyc);
      repeat (30) @(negedge clk);
      pwm_in = 1'b0;
      repeat (30) @(negedge clk);
      pwm_in = 1'b1;
      repeat (2) @(negedge clk);
      pwm_in = 1'b0;
      repeat (38) @(negedge clk);
    end
    repeat (20) @(negedge clk);
`ifdef EF_PWM_DEC32_GLITCH_FILTER_EN
    check_run("glitch_filt", 2, 32'd100, 32'd30);
`else
    check("glitch_valid_count", v_cyc.size(), 5);
    if (v_cyc.size() >= 2) begin
      check("glitch_period0", v_per[0], 32'd60);
      check("glitch_high0", v_hi[0], 32'd30);
      check("glitch_period1", v_per[1], 32'd40);
      check("glitch_high1", v_hi[1], 32'd2);
    end
`endif
    $display("glitch seq valids=%0d period=%0d high=%0d", v_cyc.size(), period, high_time);

    // Disabled block holds its results and stays silent.
    start_run(4'd8, 1'b0, 32'd5);
    timeout = 32'd0;
    drive(100, 30, 2);
    repeat (10) @(negedge clk);
    en = 1'b0;
    timeout = 32'd5;
    @(negedge clk);
    clear_q();
    drive(60, 10, 3);
    repeat (10) @(negedge clk);
    check("dis_valids", v_cyc.size(), 0);
    check("dis_to_flags", tf_cyc.size(), 0);
    check("dis_period_hold", period, 32'd100);
    check("dis_high_hold", high_time, 32'd30);
    $display("disable seq valids=%0d period=%0d high=%0d", v_cyc.size(), period, high_time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
